hit_score_engine: RTL

- Parametrised rhythm-game scoring core; replaces the hard-wired 4-lane score/weight/hit logic inside the VGA game datapath.
- Consumes PS/2 make/break events and the active target lane, judges hits and misses, and maintains:
  - a time-decaying hit weight,
  - a saturating multi-digit BCD score,
  - hit and combo counters,
  - the game-over flag.
- BCD digits feed the score sprite renderer directly.

---
 rtl/hit_score_engine.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/hit_score_engine.sv
// hit_score_engine: rhythm-game scoring core.
// Judges PS/2 key presses against the active target lane and keeps a decaying
// hit weight, a saturating BCD score, hit/combo counters and the game-over flag.
//
// Key event handshake: key_valid is a one-cycle strobe with no back-pressure.
// key_code/key_break are only meaningful while key_valid is high, and every
// strobe is consumed on the edge where it is sampled. A press is key_valid with
// key_break low; release events never affect the game. target_load is also a
// one-cycle strobe and takes priority over a key strobe in the same cycle.
module hit_score_engine #(
  parameter int                 LANES       = 4,
  parameter int                 DIGITS      = 3,
  parameter logic [8*LANES-1:0] LANE_KEYS   = {8'h2B, 8'h23, 8'h1B, 8'h1C},
  parameter int                 WEIGHT_MAX  = 7,
  parameter int                 WEIGHT_MIN  = 1,
  parameter int                 DECAY_TICKS = 10444303,
  parameter int                 MAX_HITS    = 100,
  localparam int                LW          = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                target_load,
  input  logic [LW-1:0]       target_lane,
  input  logic                key_valid,
  input  logic [7:0]          key_code,
  input  logic                key_break,
  output logic                hit,
  output logic                miss,
  output logic [4*DIGITS-1:0] score_bcd,
  output logic [3:0]          weight,
  output logic [7:0]          combo,
  output logic [7:0]          hit_count,
  output logic                game_over,
  output logic [1:0]          state_dbg
);

  localparam int CW = $clog2(DECAY_TICKS);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    LOCKED = 2'd2,
    OVER   = 2'd3
  } state_t;

  state_t              state;
  logic [LW-1:0]       lane_q;
  logic [CW-1:0]       decay_cnt;
  logic                key_match;
  logic                press;
  logic [4*DIGITS-1:0] score_sum;
  logic [4:0]          dsum;
  logic [4:0]          dadj;
  logic [3:0]          carry;

  assign press     = key_valid & ~key_break;
  assign state_dbg = state;

  // Compare the scan code against the key of the latched lane; lanes beyond
  // LANES have no key and therefore never match.
  always_comb begin
    key_match = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      if (lane_q == LW'(i) && key_code == LANE_KEYS[8*i +: 8]) key_match = 1'b1;
    end
  end

  // Ripple BCD add of the current weight into the score; overflow past the
  // last digit saturates the whole score to all nines.
  always_comb begin
    score_sum = '0;
    carry     = weight;
    dsum      = '0;
    dadj      = '0;
    for (int i = 0; i < DIGITS; i++) begin
      dsum = {1'b0, score_bcd[4*i +: 4]} + {1'b0, carry};
      dadj = dsum - 5'd10;
      if (dsum > 5'd9) begin
        score_sum[4*i +: 4] = dadj[3:0];
        carry               = 4'd1;
      end else begin
        score_sum[4*i +: 4] = dsum[3:0];
        carry               = 4'd0;
      end
    end
    if (carry != 4'd0) score_sum = {DIGITS{4'h9}};
  end

  // Game FSM with decay timer, judgement and all registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      lane_q    <= '0;
      decay_cnt <= '0;
      weight    <= 4'(WEIGHT_MAX);
      score_bcd <= '0;
      combo     <= '0;
      hit_count <= '0;
      hit       <= 1'b0;
      miss      <= 1'b0;
      game_over <= 1'b0;
    end else begin
      hit  <= 1'b0;
      miss <= 1'b0;
      if (state != OVER) begin
        if (target_load) begin
          state     <= ARMED;
          lane_q    <= target_lane;
          weight    <= 4'(WEIGHT_MAX);
          decay_cnt <= '0;
        end else begin
          if (state == ARMED || state == LOCKED) begin
            if (decay_cnt == CW'(DECAY_TICKS - 1)) begin
              decay_cnt <= '0;
              if (weight > 4'(WEIGHT_MIN)) weight <= weight - 4'd1;
            end else begin
              decay_cnt <= decay_cnt + 1'b1;
            end
          end
          if (state == ARMED && press) begin
            if (key_match) begin
              hit       <= 1'b1;
              score_bcd <= score_sum;
              hit_count <= hit_count + 8'd1;
              if (combo != 8'hFF) combo <= combo + 8'd1;
              if (hit_count + 8'd1 == 8'(MAX_HITS)) begin
                state     <= OVER;
                game_over <= 1'b1;
              end else begin
                state <= LOCKED;
              end
            end else begin
              miss  <= 1'b1;
              combo <= '0;
            end
          end
        end
      end
    end
  end

endmodule
